// File: rtl/rs_pkg.sv
// rs_pkg: shared defaults for the reservation-station functional-unit slice.
//   DEF_DATA_W / DEF_TAG_W / DEF_DEPTH / DEF_OP_W : default parameter values.
//   TAG_NONE : tag value meaning "no producer, operand value is present".
package rs_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_TAG_W  = 3;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_OP_W   = 3;
    localparam int TAG_NONE   = 0;

endpackage

// File: rtl/rs_age_arbiter.sv
// rs_age_arbiter: picks the oldest ready entry (lowest age rank).
// Ports:
//   i_ready : per-entry ready flags
//   i_ranks : per-entry age rank, packed, entry i at [i*RANK_W +: RANK_W]
//   o_grant : one-hot grant of the oldest ready entry
//   o_any   : at least one entry is ready
module rs_age_arbiter
    import rs_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int RANK_W = $clog2(DEF_DEPTH)
) (
    input  logic [DEPTH-1:0]        i_ready,
    input  logic [DEPTH*RANK_W-1:0] i_ranks,
    output logic [DEPTH-1:0]        o_grant,
    output logic                    o_any
);

    logic [DEPTH-1:0] w_beaten;

    // Ranks of busy entries are unique; the index tie-break only keeps the
    // grant one-hot should that ever not hold.
    always_comb begin
        w_beaten = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (i_ready[j] && (j != i)) begin
                    if ((i_ranks[j*RANK_W +: RANK_W] < i_ranks[i*RANK_W +: RANK_W]) ||
                        ((i_ranks[j*RANK_W +: RANK_W] == i_ranks[i*RANK_W +: RANK_W]) && (j < i))) begin
                        w_beaten[i] = 1'b1;
                    end
                end
            end
        end
        o_grant = i_ready & ~w_beaten;
        o_any   = |i_ready;
    end

endmodule

// File: rtl/estacao_reserva_uf.sv
// estacao_reserva_uf: reservation station in front of one functional unit.
// Holds DEPTH instructions waiting for operands, snoops the CDB for results,
// and dispatches the oldest ready instruction through a one-deep output register.
// Ports:
//   Clock, Reset (async, active-high), Flush (sync clear of all entries)
//   Issue_*  : new instruction in (valid/ready handshake, op, Vj/Qj, Vk/Qk, dest)
//   CDB_*    : common data bus broadcast (valid, tag, data)
//   Disp_*   : dispatch to the functional unit (valid/ready, op, A, B, dest)
//   Count    : busy entries, not counting the dispatch register
module estacao_reserva_uf
    import rs_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int OP_W   = DEF_OP_W
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Flush,
    input  logic                   Issue_valid,
    output logic                   Issue_ready,
    input  logic [OP_W-1:0]        Issue_op,
    input  logic [DATA_W-1:0]      Issue_Vj,
    input  logic [DATA_W-1:0]      Issue_Vk,
    input  logic [TAG_W-1:0]       Issue_Qj,
    input  logic [TAG_W-1:0]       Issue_Qk,
    input  logic [TAG_W-1:0]       Issue_dest,
    input  logic                   CDB_valid,
    input  logic [TAG_W-1:0]       CDB_tag,
    input  logic [DATA_W-1:0]      CDB_data,
    output logic                   Disp_valid,
    input  logic                   Disp_ready,
    output logic [OP_W-1:0]        Disp_op,
    output logic [DATA_W-1:0]      Disp_A,
    output logic [DATA_W-1:0]      Disp_B,
    output logic [TAG_W-1:0]       Disp_dest,
    output logic [$clog2(DEPTH):0] Count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // Entry state
    logic [DEPTH-1:0]  r_busy;
    logic [OP_W-1:0]   r_op   [DEPTH];
    logic [TAG_W-1:0]  r_dest [DEPTH];
    logic [TAG_W-1:0]  r_qj   [DEPTH];
    logic [TAG_W-1:0]  r_qk   [DEPTH];
    logic [DATA_W-1:0] r_vj   [DEPTH];
    logic [DATA_W-1:0] r_vk   [DEPTH];
    logic [IDX_W-1:0]  r_rank [DEPTH];

    // Dispatch register
    logic              r_disp_valid;
    logic [OP_W-1:0]   r_disp_op;
    logic [DATA_W-1:0] r_disp_a;
    logic [DATA_W-1:0] r_disp_b;
    logic [TAG_W-1:0]  r_disp_dest;

    logic [DEPTH-1:0]       w_ready;
    logic [DEPTH*IDX_W-1:0] w_ranks_flat;
    logic [DEPTH-1:0]       w_grant;
    logic                   w_any;
    logic                   w_load;
    logic                   w_disp_fire;
    logic [IDX_W-1:0]       w_disp_idx;
    logic [IDX_W-1:0]       w_disp_rank;
    logic [IDX_W-1:0]       w_free_idx;
    logic                   w_free_found;
    logic                   w_issue_fire;
    logic [CNT_W-1:0]       w_count;
    logic [IDX_W-1:0]       w_new_rank;
    logic                   w_cdb_hit;
    logic                   w_fwd_j;
    logic                   w_fwd_k;

    always_comb begin
        w_ready      = '0;
        w_ranks_flat = '0;
        w_count      = '0;
        w_free_idx   = '0;
        w_free_found = 1'b0;
        w_disp_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_ready[i] = r_busy[i] && (r_qj[i] == TAG_W'(TAG_NONE)) && (r_qk[i] == TAG_W'(TAG_NONE));
            w_ranks_flat[i*IDX_W +: IDX_W] = r_rank[i];
            w_count = w_count + CNT_W'(r_busy[i]);
            if (!r_busy[i] && !w_free_found) begin
                w_free_idx   = IDX_W'(i);
                w_free_found = 1'b1;
            end
            if (w_grant[i]) begin
                w_disp_idx = w_disp_idx | IDX_W'(i);
            end
        end
    end

    rs_age_arbiter #(
        .DEPTH  (DEPTH),
        .RANK_W (IDX_W)
    ) u_age_arbiter (
        .i_ready (w_ready),
        .i_ranks (w_ranks_flat),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    assign Issue_ready  = ~&r_busy;
    assign w_issue_fire = Issue_valid && Issue_ready;
    assign w_load       = !r_disp_valid || Disp_ready;
    assign w_disp_fire  = w_load && w_any;
    assign w_disp_rank  = r_rank[w_disp_idx];
    // New entry is the youngest: its rank is the number of entries still busy
    // after this edge's dispatch. Issue only fires when not full, so this fits.
    assign w_new_rank   = IDX_W'(w_count - CNT_W'(w_disp_fire));
    assign w_cdb_hit    = CDB_valid && (CDB_tag != TAG_W'(TAG_NONE));
    assign w_fwd_j      = w_cdb_hit && (CDB_tag == Issue_Qj);
    assign w_fwd_k      = w_cdb_hit && (CDB_tag == Issue_Qk);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_busy       <= '0;
            r_disp_valid <= 1'b0;
            r_disp_op    <= '0;
            r_disp_a     <= '0;
            r_disp_b     <= '0;
            r_disp_dest  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_op[i]   <= '0;
                r_dest[i] <= '0;
                r_qj[i]   <= '0;
                r_qk[i]   <= '0;
                r_vj[i]   <= '0;
                r_vk[i]   <= '0;
                r_rank[i] <= '0;
            end
        end else if (Flush) begin
            r_busy       <= '0;
            r_disp_valid <= 1'b0;
            r_disp_op    <= '0;
            r_disp_a     <= '0;
            r_disp_b     <= '0;
            r_disp_dest  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_rank[i] <= '0;
            end
        end else begin
            // CDB snoop and age update on busy entries
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (r_busy[i]) begin
                    if (w_cdb_hit && (r_qj[i] == CDB_tag)) begin
                        r_vj[i] <= CDB_data;
                        r_qj[i] <= TAG_W'(TAG_NONE);
                    end
                    if (w_cdb_hit && (r_qk[i] == CDB_tag)) begin
                        r_vk[i] <= CDB_data;
                        r_qk[i] <= TAG_W'(TAG_NONE);
                    end
                    if (w_disp_fire && (r_rank[i] > w_disp_rank)) begin
                        r_rank[i] <= r_rank[i] - IDX_W'(1);
                    end
                end
            end

            if (w_disp_fire) begin
                r_busy[w_disp_idx] <= 1'b0;
                r_rank[w_disp_idx] <= '0;
            end

            // Allocation targets a pre-edge free entry, never the dispatched one
            if (w_issue_fire) begin
                r_busy[w_free_idx] <= 1'b1;
                r_op[w_free_idx]   <= Issue_op;
                r_dest[w_free_idx] <= Issue_dest;
                r_vj[w_free_idx]   <= w_fwd_j ? CDB_data : Issue_Vj;
                r_qj[w_free_idx]   <= w_fwd_j ? TAG_W'(TAG_NONE) : Issue_Qj;
                r_vk[w_free_idx]   <= w_fwd_k ? CDB_data : Issue_Vk;
                r_qk[w_free_idx]   <= w_fwd_k ? TAG_W'(TAG_NONE) : Issue_Qk;
                r_rank[w_free_idx] <= w_new_rank;
            end

            if (w_load) begin
                r_disp_valid <= w_any;
                if (w_any) begin
                    r_disp_op   <= r_op[w_disp_idx];
                    r_disp_a    <= r_vj[w_disp_idx];
                    r_disp_b    <= r_vk[w_disp_idx];
                    r_disp_dest <= r_dest[w_disp_idx];
                end
            end
        end
    end

    assign Disp_valid = r_disp_valid;
    assign Disp_op    = r_disp_op;
    assign Disp_A     = r_disp_a;
    assign Disp_B     = r_disp_b;
    assign Disp_dest  = r_disp_dest;
    assign Count      = w_count;

endmodule

// File: tb/tb_estacao_reserva_uf.sv
// tb_estacao_reserva_uf: directed self-checking bench for estacao_reserva_uf.
module tb_estacao_reserva_uf;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Flush;
    logic        Issue_valid;
    logic        Issue_ready;
    logic [2:0]  Issue_op;
    logic [15:0] Issue_Vj;
    logic [15:0] Issue_Vk;
    logic [2:0]  Issue_Qj;
    logic [2:0]  Issue_Qk;
    logic [2:0]  Issue_dest;
    logic        CDB_valid;
    logic [2:0]  CDB_tag;
    logic [15:0] CDB_data;
    logic        Disp_valid;
    logic        Disp_ready;
    logic [2:0]  Disp_op;
    logic [15:0] Disp_A;
    logic [15:0] Disp_B;
    logic [2:0]  Disp_dest;
    logic [2:0]  Count;

    int n_checks = 0;
    int n_errors = 0;

    estacao_reserva_uf #(
        .DATA_W (16),
        .TAG_W  (3),
        .DEPTH  (4),
        .OP_W   (3)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Flush       (Flush),
        .Issue_valid (Issue_valid),
        .Issue_ready (Issue_ready),
        .Issue_op    (Issue_op),
        .Issue_Vj    (Issue_Vj),
        .Issue_Vk    (Issue_Vk),
        .Issue_Qj    (Issue_Qj),
        .Issue_Qk    (Issue_Qk),
        .Issue_dest  (Issue_dest),
        .CDB_valid   (CDB_valid),
        .CDB_tag     (CDB_tag),
        .CDB_data    (CDB_data),
        .Disp_valid  (Disp_valid),
        .Disp_ready  (Disp_ready),
        .Disp_op     (Disp_op),
        .Disp_A      (Disp_A),
        .Disp_B      (Disp_B),
        .Disp_dest   (Disp_dest),
        .Count       (Count)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] vj, input logic [15:0] vk,
                         input logic [2:0] qj, input logic [2:0] qk, input logic [2:0] dest);
        Issue_valid = 1'b1;
        Issue_op    = op;
        Issue_Vj    = vj;
        Issue_Vk    = vk;
        Issue_Qj    = qj;
        Issue_Qk    = qk;
        Issue_dest  = dest;
    endtask

    task automatic cdb(input logic v, input logic [2:0] tag, input logic [15:0] data);
        CDB_valid = v;
        CDB_tag   = tag;
        CDB_data  = data;
    endtask

    task automatic chk_disp(input string tag, input logic [2:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [2:0] dest);
        chk({tag, "_valid"}, 32'(Disp_valid), 32'd1);
        chk({tag, "_op"},    32'(Disp_op),    32'(op));
        chk({tag, "_A"},     32'(Disp_A),     32'(a));
        chk({tag, "_B"},     32'(Disp_B),     32'(b));
        chk({tag, "_dest"},  32'(Disp_dest),  32'(dest));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Flush = 1'b0; Disp_ready = 1'b1;
        Issue_valid = 1'b0; Issue_op = '0; Issue_Vj = '0; Issue_Vk = '0;
        Issue_Qj = '0; Issue_Qk = '0; Issue_dest = '0;
        cdb(1'b0, 3'd0, 16'h0);
        step(); step();

        // Reset state
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_dvalid", 32'(Disp_valid), 32'd0);
        chk("rst_iready", 32'(Issue_ready), 32'd1);
        chk("rst_A", 32'(Disp_A), 32'd0);
        chk("rst_dest", 32'(Disp_dest), 32'd0);
        Reset = 1'b0;
        step();

        // Ready-at-issue instruction: dispatch after second edge
        issue(3'd1, 16'd5, 16'd7, 3'd0, 3'd0, 3'd1);
        step();
        Issue_valid = 1'b0;
        chk("t1_count1", 32'(Count), 32'd1);
        chk("t1_dv0", 32'(Disp_valid), 32'd0);
        step();
        chk_disp("t1", 3'd1, 16'd5, 16'd7, 3'd1);
        chk("t1_count0", 32'(Count), 32'd0);
        step();
        chk("t1_drain", 32'(Disp_valid), 32'd0);

        // Two pending operands captured on separate broadcasts
        issue(3'd2, 16'h0, 16'h0, 3'd2, 3'd3, 3'd4);
        step();
        Issue_valid = 1'b0;
        cdb(1'b1, 3'd3, 16'd9);
        chk("t2_count", 32'(Count), 32'd1);
        step();
        cdb(1'b1, 3'd2, 16'd4);
        chk("t2_dv_a", 32'(Disp_valid), 32'd0);
        step();
        cdb(1'b0, 3'd0, 16'h0);
        chk("t2_dv_b", 32'(Disp_valid), 32'd0);
        step();
        chk_disp("t2", 3'd2, 16'd4, 16'd9, 3'd4);
        step();
        chk("t2_drain", 32'(Disp_valid), 32'd0);

        // Same-cycle forwarding on both operands
        issue(3'd3, 16'h1111, 16'h2222, 3'd5, 3'd5, 3'd5);
        cdb(1'b1, 3'd5, 16'h00AB);
        step();
        Issue_valid = 1'b0;
        cdb(1'b0, 3'd0, 16'h0);
        chk("t3_count", 32'(Count), 32'd1);
        step();
        chk_disp("t3", 3'd3, 16'h00AB, 16'h00AB, 3'd5);
        chk("t3_count0", 32'(Count), 32'd0);
        step();

        // Tag 0 on the CDB must not touch present operands
        issue(3'd4, 16'h0012, 16'h0, 3'd0, 3'd1, 3'd6);
        cdb(1'b1, 3'd0, 16'h00EE);
        step();
        Issue_valid = 1'b0;
        cdb(1'b1, 3'd0, 16'h00DD);
        step();
        cdb(1'b1, 3'd1, 16'h0021);
        step();
        cdb(1'b0, 3'd0, 16'h0);
        chk("t4_dv0", 32'(Disp_valid), 32'd0);
        step();
        chk_disp("t4", 3'd4, 16'h0012, 16'h0021, 3'd6);
        step();

        // Fill, stall, dispatch in age order
        Disp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            issue(3'(k), 16'h0, 16'(16'h100 + k), 3'd6, 3'd0, 3'(k + 1));
            step();
        end
        Issue_valid = 1'b0;
        chk("t5_full_count", 32'(Count), 32'd4);
        chk("t5_full_iready", 32'(Issue_ready), 32'd0);
        chk("t5_full_dv", 32'(Disp_valid), 32'd0);
        issue(3'd7, 16'h0, 16'h0, 3'd7, 3'd0, 3'd7);
        step();
        Issue_valid = 1'b0;
        chk("t5_refused", 32'(Count), 32'd4);
        cdb(1'b1, 3'd6, 16'h0066);
        step();
        cdb(1'b0, 3'd0, 16'h0);
        chk("t5_dv_cap", 32'(Disp_valid), 32'd0);
        step();
        chk_disp("t5_d1", 3'd0, 16'h0066, 16'h0100, 3'd1);
        chk("t5_cnt3", 32'(Count), 32'd3);
        step();
        chk_disp("t5_hold1", 3'd0, 16'h0066, 16'h0100, 3'd1);
        chk("t5_iready1", 32'(Issue_ready), 32'd1);
        issue(3'd7, 16'h0, 16'h0077, 3'd7, 3'd0, 3'd7);
        step();
        Issue_valid = 1'b0;
        chk("t5_cnt4", 32'(Count), 32'd4);
        chk("t5_hold2", 32'(Disp_dest), 32'd1);
        // Full while dispatch handshakes: issue must be refused
        issue(3'd6, 16'h0, 16'h0, 3'd0, 3'd0, 3'd6);
        Disp_ready = 1'b1;
        chk("t5_iready0", 32'(Issue_ready), 32'd0);
        step();
        Issue_valid = 1'b0;
        Disp_ready = 1'b0;
        chk_disp("t5_d2", 3'd1, 16'h0066, 16'h0101, 3'd2);
        chk("t5_cnt3b", 32'(Count), 32'd3);
        step();
        chk("t5_hold3", 32'(Disp_dest), 32'd2);
        cdb(1'b1, 3'd7, 16'h0070);
        step();
        cdb(1'b0, 3'd0, 16'h0);
        Disp_ready = 1'b1;
        step();
        chk_disp("t5_d3", 3'd2, 16'h0066, 16'h0102, 3'd3);
        chk("t5_cnt2", 32'(Count), 32'd2);
        step();
        chk_disp("t5_d4", 3'd3, 16'h0066, 16'h0103, 3'd4);
        step();
        chk_disp("t5_d7", 3'd7, 16'h0070, 16'h0077, 3'd7);
        chk("t5_cnt0", 32'(Count), 32'd0);
        step();
        chk("t5_drain", 32'(Disp_valid), 32'd0);

        // Flush mid-stall, with a concurrent issue attempt
        Disp_ready = 1'b0;
        issue(3'd1, 16'h0, 16'h0, 3'd1, 3'd0, 3'd1); step();
        issue(3'd2, 16'h0, 16'h0, 3'd0, 3'd2, 3'd2); step();
        issue(3'd3, 16'h33, 16'h44, 3'd0, 3'd0, 3'd3); step();
        Issue_valid = 1'b0;
        step();
        chk("t6_pre_cnt", 32'(Count), 32'd2);
        chk("t6_pre_dest", 32'(Disp_dest), 32'd3);
        Flush = 1'b1;
        issue(3'd5, 16'h0, 16'h0, 3'd0, 3'd0, 3'd5);
        step();
        Flush = 1'b0;
        Issue_valid = 1'b0;
        chk("t6_cnt", 32'(Count), 32'd0);
        chk("t6_dv", 32'(Disp_valid), 32'd0);
        chk("t6_iready", 32'(Issue_ready), 32'd1);
        Disp_ready = 1'b1;
        cdb(1'b1, 3'd1, 16'h1); step();
        cdb(1'b1, 3'd2, 16'h2); step();
        cdb(1'b0, 3'd0, 16'h0); step();
        chk("t6_post_dv", 32'(Disp_valid), 32'd0);

        // Asynchronous reset mid-stall
        Disp_ready = 1'b0;
        issue(3'd1, 16'h0, 16'h0, 3'd1, 3'd0, 3'd1); step();
        issue(3'd2, 16'h0, 16'h0, 3'd0, 3'd2, 3'd2); step();
        issue(3'd3, 16'h33, 16'h44, 3'd0, 3'd0, 3'd3); step();
        Issue_valid = 1'b0;
        step();
        chk("t7_pre_dv", 32'(Disp_valid), 32'd1);
        Reset = 1'b1;
        #1;
        chk("t7_cnt", 32'(Count), 32'd0);
        chk("t7_dv", 32'(Disp_valid), 32'd0);
        chk("t7_iready", 32'(Issue_ready), 32'd1);
        chk("t7_A", 32'(Disp_A), 32'd0);
        chk("t7_dest", 32'(Disp_dest), 32'd0);
        step();
        Reset = 1'b0;
        Disp_ready = 1'b1;
        step();
        chk("t7_post_dv", 32'(Disp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/estacao_reserva_uf.md
ESTACAO_RESERVA_UF -- requirements
Module: estacao_reserva_uf

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, operand/result width.
REQ-002 The block SHALL have parameter TAG_W, default 3, reservation-station tag width; tag 0 means "no producer, value present".
REQ-003 The block SHALL have parameter DEPTH, default 4, number of entries (2..16).
REQ-004 The block SHALL have parameter OP_W, default 3, opcode width.
REQ-005 The block SHALL have port Clock, input, 1, sole clock; all state changes on its rising edge.
REQ-006 The block SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port Flush, input, 1, synchronous clear of all entries.
REQ-008 The block SHALL have ports Issue_valid (in, 1), Issue_ready (out, 1), Issue_op (in, OP_W), Issue_Vj/Issue_Vk (in, DATA_W), Issue_Qj/Issue_Qk (in, TAG_W) and Issue_dest (in, TAG_W), carrying the new instruction.
REQ-009 The block SHALL have ports CDB_valid (in, 1), CDB_tag (in, TAG_W) and CDB_data (in, DATA_W), the common data bus broadcast.
REQ-010 The block SHALL have ports Disp_valid (out, 1), Disp_ready (in, 1), Disp_op (out, OP_W), Disp_A/Disp_B (out, DATA_W) and Disp_dest (out, TAG_W), carrying the dispatch to the functional unit.
REQ-011 The block SHALL have port Count, output, clog2(DEPTH)+1, number of busy entries.

Function
REQ-012 Issue_ready SHALL be 1 when at least one entry is free; it SHALL be combinational from entry state only.
REQ-013 An issue handshake (Issue_valid&&Issue_ready) SHALL allocate the lowest-index free entry, storing op, dest, Vj/Qj and Vk/Qk.
REQ-014 On issue, if CDB_valid and CDB_tag!=0 equals Issue_Qj (resp. Issue_Qk), the entry SHALL store CDB_data with Q=0 (same-cycle forwarding).
REQ-015 Each cycle, every busy entry with Qj!=0 (resp. Qk!=0) matching a valid CDB_tag SHALL capture CDB_data into Vj (resp. Vk) and clear Qj (resp. Qk); both operands may capture in the same cycle.
REQ-016 CDB_tag==0 SHALL never match any operand.
REQ-017 An entry SHALL be ready when busy and Qj==0 and Qk==0.
REQ-018 Each entry SHALL hold an age rank; on allocation, rank = busy entries remaining after this edge's dispatch; on dispatch of rank r, all ranks > r SHALL decrement.
REQ-019 The dispatch register SHALL be loaded with the ready entry of lowest rank (oldest) whenever it is empty or is handshaking (Disp_valid&&Disp_ready) in that cycle; the loaded entry SHALL be freed on the same edge.
REQ-020 Disp_valid and Disp_op/A/B/dest SHALL stay stable while Disp_valid&&!Disp_ready.
REQ-021 Latency: an entry that becomes ready at edge t SHALL appear with Disp_valid=1 after edge t+1 if the dispatch register is free.
REQ-022 Simultaneous issue and dispatch when full SHALL NOT be accepted (Issue_ready uses pre-edge state).
REQ-023 Flush SHALL clear all entries, Count and Disp_valid on the next edge, overriding issue, capture and dispatch.
REQ-024 Count SHALL equal busy entries, excluding the dispatch register.

Reset
REQ-025 On Reset all entries SHALL be free, all ranks 0, Count=0, Disp_valid=0, Disp_op/A/B/dest=0, Issue_ready=1, regardless of operation in progress.

Structure
REQ-026 Package rs_pkg SHALL hold default DATA_W/TAG_W/DEPTH/OP_W and constant TAG_NONE=0.
REQ-027 Oldest-ready selection SHALL be a sub-module rs_age_arbiter (inputs ready vector, ranks; output one-hot grant, any).

Verification
REQ-028 Reset, issue op=1 Vj=5 Vk=7 Qj=Qk=0 -> Disp_valid after second edge, A=5 B=7, Count back to 0.
REQ-029 Issue Qj=2 Qk=3; CDB tag 3 data 9, then tag 2 data 4 -> Disp A=4 B=9 one edge after tag-2 capture.
REQ-030 Issue Qj=Qk=5 while CDB_valid tag 5 data 0x00AB -> entry ready immediately, A=B=0x00AB.
REQ-031 Fill 4 entries waiting on tag 6, hold Disp_ready=0 -> Issue_ready=0; CDB tag 6 -> dispatch in issue order, each held until Disp_ready.
REQ-032 Entries 0,1 pending, entry 2 ready, Flush or Reset mid-stall -> Count=0, Disp_valid=0, Issue_ready=1 next cycle.
